// File: rtl/forward_scoreboard.sv
// Decode-stage operand bypass and long-latency hazard scoreboard.
// Resolves each source operand from the youngest in-flight writer and raises decode_wait when it cannot.
module forward_scoreboard #(
  parameter int NREAD  = 2,
  parameter int NSTAGE = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ra        [NREAD],
  input  logic [63:0]       rd        [NREAD],
  output logic [63:0]       rs        [NREAD],
  input  logic              fwd_valid [NSTAGE],
  input  logic [4:0]        fwd_wa    [NSTAGE],
  input  logic [63:0]       fwd_data  [NSTAGE],
  input  logic              fwd_ready [NSTAGE],
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic              done_valid,
  input  logic [4:0]        done_rd,
  output logic              decode_wait,
  output logic [31:0]       busy,
  output logic [CNT_W-1:0]  stall_count
);

  logic [NREAD-1:0] port_stall;
  logic             found;
  logic             sel_ready;
  logic [63:0]      sel_data;
  logic [31:0]      busy_d;

  always_comb begin
    port_stall = '0;
    found      = 1'b0;
    sel_ready  = 1'b0;
    sel_data   = '0;
    for (int p = 0; p < NREAD; p++) begin
      found     = 1'b0;
      sel_ready = 1'b0;
      sel_data  = '0;
      rs[p]     = '0;
      // Scan oldest to youngest so the youngest match overwrites older ones.
      for (int s = NSTAGE - 1; s >= 0; s--) begin
        if (fwd_valid[s] && (fwd_wa[s] == ra[p])) begin
          found     = 1'b1;
          sel_ready = fwd_ready[s];
          sel_data  = fwd_data[s];
        end
      end
      if (ra[p] != 5'd0) begin
        if (found) begin
          if (sel_ready) rs[p] = sel_data;
          else           port_stall[p] = 1'b1;
        end else if (busy[ra[p]] && !(done_valid && (done_rd == ra[p]))) begin
          port_stall[p] = 1'b1;
        end else begin
          rs[p] = rd[p];
        end
      end
    end
  end

  assign decode_wait = |port_stall;

  // Set after clear: a same-cycle issue is the younger writer.
  always_comb begin
    busy_d = busy;
    if (done_valid) busy_d[done_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      stall_count <= '0;
    end else begin
      busy <= busy_d;
      if (decode_wait && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule
